// File: rtl/qa_capture_replay_pkg.sv
// qa_capture_replay_pkg: shared definitions for the capture/replay buffer.
// Holds the mode-FSM state encoding, the command opcodes and response codes
// carried in the top four bits of the message words, and a helper that sizes
// the sample counter.
package qa_capture_replay_pkg;

   // Numeric values are reported verbatim in the STAT response state field.
   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCapture = 2'd1,
      StReplay  = 2'd2
   } state_e;

   localparam int unsigned OpcodeBits = 4;

   // Command opcodes (in_msg top nibble)
   localparam logic [3:0] OpCapture = 4'd1;
   localparam logic [3:0] OpReplay  = 4'd2;
   localparam logic [3:0] OpClear   = 4'd3;
   localparam logic [3:0] OpStatus  = 4'd4;

   // Response codes (out_msg top nibble)
   localparam logic [3:0] RespDoneCap = 4'd8;
   localparam logic [3:0] RespDoneRep = 4'd9;
   localparam logic [3:0] RespStat    = 4'd10;

   // Counter width able to hold the value DEPTH itself.
   function automatic int unsigned count_bits(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/qa_buffer_ram.sv
// qa_buffer_ram: simple dual-port sample store, DEPTH x DW.
// Synchronous write; registered read with one cycle of latency. The read
// register is reset so the replay outputs start at zero; the array is not.
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en/addr/data   write port
//   rd_en/addr        read request
//   rd_data           registered read data
module qa_buffer_ram #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned DW    = 33
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DW-1:0]            wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DW-1:0]            rd_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/qa_capture_replay.sv
// qa_capture_replay: message-controlled capture/replay buffer for QA.
// Commands on in_msg select capture of up to DEPTH {meta,data} samples from
// the in_* stream, replay of the stored samples on out_*, clear, or status.
// Completion and status words are returned on out_msg; protocol violations
// raise the sticky error output until CLEAR or reset.
//   clk, rst_n               clock, asynchronous active-low reset
//   in_data/in_nd/in_m       sample stream being captured
//   in_msg/in_msg_nd         command word
//   out_data/out_nd/out_m    replayed sample stream
//   out_msg/out_msg_nd       response word
//   error                    sticky protocol error
module qa_capture_replay
   import qa_capture_replay_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned MWIDTH    = 1,
   parameter int unsigned MSG_WIDTH = 32,
   parameter int unsigned DEPTH     = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_nd,
   input  logic [MWIDTH-1:0]    in_m,
   input  logic [MSG_WIDTH-1:0] in_msg,
   input  logic                 in_msg_nd,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_nd,
   output logic [MWIDTH-1:0]    out_m,
   output logic [MSG_WIDTH-1:0] out_msg,
   output logic                 out_msg_nd,
   output logic                 error
);

   localparam int unsigned CW = count_bits(DEPTH);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = WIDTH + MWIDTH;

   state_e               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [CW-1:0]        target_q, target_d;
   logic [CW-1:0]        rd_idx_q, rd_idx_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 rd_last_q, rd_last_d;
   logic                 error_q, error_d;
   logic                 pend_q, pend_d;
   logic [MSG_WIDTH-1:0] pend_msg_q, pend_msg_d;
   logic [MSG_WIDTH-1:0] msg_q, msg_d;
   logic                 msg_nd_q, msg_nd_d;

   logic [3:0]           opcode;
   logic [CW-1:0]        arg;
   logic [CW-1:0]        cap_len;
   logic                 cmd_clear;
   logic                 wr_en, rd_en;
   logic                 done_v, stat_req;
   logic [MSG_WIDTH-1:0] done_msg, stat_msg;
   logic [DW-1:0]        rd_data;

   assign opcode    = in_msg[MSG_WIDTH-1 -: OpcodeBits];
   assign arg       = in_msg[CW-1:0];
   assign cap_len   = (arg == '0 || arg > CW'(DEPTH)) ? CW'(DEPTH) : arg;
   assign cmd_clear = in_msg_nd && (opcode == OpClear);

   // Bits between the opcode and the argument carry nothing; the top read
   // index bit only matters for the end-of-replay compare.
   logic unused_bits;
   assign unused_bits = ^{in_msg[MSG_WIDTH-OpcodeBits-1:CW], rd_idx_q[CW-1:AW]};

   function automatic logic [MSG_WIDTH-1:0] resp(input logic [3:0]  code,
                                                  input logic [CW+2:0] body);
      logic [MSG_WIDTH-1:0] w;
      w = '0;
      w[MSG_WIDTH-1 -: OpcodeBits] = code;
      w[CW+2:0] = body;
      return w;
   endfunction

   qa_buffer_ram #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (count_q[AW-1:0]),
      .wr_data ({in_m, in_data}),
      .rd_en   (rd_en),
      .rd_addr (rd_idx_q[AW-1:0]),
      .rd_data (rd_data)
   );

   // Mode FSM, counters and command decode.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      target_d   = target_q;
      rd_idx_d   = rd_idx_q;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      error_d    = error_q;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      done_v     = 1'b0;
      done_msg   = '0;
      stat_req   = 1'b0;

      unique case (state_q)
         StCapture: begin
            if (in_nd && !cmd_clear) begin
               wr_en   = 1'b1;
               count_d = count_q + CW'(1);
               if (count_d == target_q) begin
                  done_v   = 1'b1;
                  done_msg = resp(RespDoneCap, {3'b000, count_d});
                  state_d  = StIdle;
               end
            end
         end
         StReplay: begin
            rd_en      = 1'b1;
            rd_valid_d = 1'b1;
            rd_idx_d   = rd_idx_q + CW'(1);
            if (rd_idx_d == count_q) begin
               rd_last_d = 1'b1;
               state_d   = StIdle;
            end
         end
         default: ;
      endcase

      // Last replayed sample is on the outputs now; completion follows it.
      if (rd_last_q) begin
         done_v   = 1'b1;
         done_msg = resp(RespDoneRep, {3'b000, count_q});
      end

      if (in_msg_nd) begin
         case (opcode)
            OpCapture: begin
               if (state_q == StIdle) begin
                  state_d  = StCapture;
                  count_d  = '0;
                  target_d = cap_len;
               end else begin
                  error_d = 1'b1;
               end
            end
            OpReplay: begin
               if (state_q != StIdle) begin
                  error_d = 1'b1;
               end else if (count_q == '0) begin
                  done_v   = 1'b1;
                  done_msg = resp(RespDoneRep, '0);
               end else begin
                  state_d  = StReplay;
                  rd_idx_d = '0;
               end
            end
            OpClear: begin
               state_d    = StIdle;
               count_d    = '0;
               error_d    = 1'b0;
               // Abort any read issued this cycle so no sample escapes late.
               rd_valid_d = 1'b0;
               rd_last_d  = 1'b0;
            end
            OpStatus: stat_req = 1'b1;
            default:  error_d = 1'b1;
         endcase
      end
   end

   // Status reflects the state as it will be on the next cycle.
   assign stat_msg = resp(RespStat, {state_d, error_q, count_d});

   // Response mux: completion wins, a colliding STAT waits one cycle.
   always_comb begin
      msg_nd_d   = 1'b0;
      msg_d      = '0;
      pend_d     = pend_q;
      pend_msg_d = pend_msg_q;
      if (done_v) begin
         msg_nd_d = 1'b1;
         msg_d    = done_msg;
         if (stat_req) begin
            pend_d     = 1'b1;
            pend_msg_d = stat_msg;
         end
      end else if (pend_q) begin
         msg_nd_d = 1'b1;
         msg_d    = pend_msg_q;
         pend_d   = 1'b0;
      end else if (stat_req) begin
         msg_nd_d = 1'b1;
         msg_d    = stat_msg;
      end
   end

   // error_d is final here: a STATUS arriving while one is pending is dropped.
   logic error_nxt;
   assign error_nxt = error_d || (stat_req && pend_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         count_q    <= '0;
         target_q   <= '0;
         rd_idx_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         error_q    <= 1'b0;
         pend_q     <= 1'b0;
         pend_msg_q <= '0;
         msg_q      <= '0;
         msg_nd_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         target_q   <= target_d;
         rd_idx_q   <= rd_idx_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         error_q    <= error_nxt;
         pend_q     <= pend_d;
         pend_msg_q <= pend_msg_d;
         msg_q      <= msg_d;
         msg_nd_q   <= msg_nd_d;
      end
   end

   assign out_data   = rd_data[WIDTH-1:0];
   assign out_m      = rd_data[DW-1 -: MWIDTH];
   assign out_nd     = rd_valid_q;
   assign out_msg    = msg_q;
   assign out_msg_nd = msg_nd_q;
   assign error      = error_q;

endmodule

// File: tb/tb_qa_capture_replay.sv
// Scoreboard bench for qa_capture_replay: a cycle-stamped reference model
// predicts every replayed sample, every response word and the error line.
module tb_qa_capture_replay;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_nd;
   logic [0:0]  in_m;
   logic [31:0] in_msg;
   logic        in_msg_nd;
   logic [31:0] out_data;
   logic        out_nd;
   logic [0:0]  out_m;
   logic [31:0] out_msg;
   logic        out_msg_nd;
   logic        error;

   qa_capture_replay #(
      .WIDTH     (32),
      .MWIDTH    (1),
      .MSG_WIDTH (32),
      .DEPTH     (64)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_nd      (in_nd),
      .in_m       (in_m),
      .in_msg     (in_msg),
      .in_msg_nd  (in_msg_nd),
      .out_data   (out_data),
      .out_nd     (out_nd),
      .out_m      (out_m),
      .out_msg    (out_msg),
      .out_msg_nd (out_msg_nd),
      .error      (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [32:0] val; } samp_t;
   typedef struct { int cyc; logic [31:0] word; bit is_rep; } msg_t;

   samp_t exp_s[$];
   msg_t  exp_m[$];

   // Reference model: mode 0 idle, 1 capture, 2 replay (replay ends by cycle).
   int          md_mode, md_count, md_target, md_rep_end, md_pend;
   bit          md_err;
   logic [32:0] md_buf [64];

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mk(input int code, input int body);
      logic [31:0] w;
      w = 32'(body);
      w[31:28] = code[3:0];
      return w;
   endfunction

   function automatic int mode_at(input int c);
      if (md_mode == 2 && c > md_rep_end) return 0;
      return md_mode;
   endfunction

   function automatic bit msg_at(input int c);
      foreach (exp_m[i]) if (exp_m[i].cyc == c) return 1'b1;
      return 1'b0;
   endfunction

   task automatic push_msg(input int c, input logic [31:0] w, input bit is_rep);
      msg_t e;
      e.cyc = c; e.word = w; e.is_rep = is_rep;
      exp_m.push_back(e);
   endtask

   task automatic model_reset();
      exp_s.delete();
      exp_m.delete();
      md_mode = 0; md_count = 0; md_target = 0; md_rep_end = 0;
      md_pend = -100; md_err = 1'b0;
   endtask

   // One cycle of inputs presented at cycle c; outputs follow from c+1.
   task automatic model_step(input bit cv, input int op, input int arg, input bit nd,
                             input logic [31:0] d, input bit m);
      int c, st, ns;
      bit clr;
      samp_t s;
      c   = cyc;
      st  = mode_at(c);
      md_mode = st;
      clr = cv && (op == 3);
      if (st == 1 && nd && !clr) begin
         md_buf[md_count] = {m, d};
         md_count++;
         if (md_count == md_target) begin
            push_msg(c + 1, mk(8, md_count), 1'b0);
            md_mode = 0;
         end
      end
      if (cv) begin
         case (op)
            1: if (st == 0) begin
                  md_mode = 1; md_count = 0;
                  md_target = (arg == 0 || arg > 64) ? 64 : arg;
               end else md_err = 1'b1;
            2: if (st != 0) md_err = 1'b1;
               else if (md_count == 0) push_msg(c + 1, mk(9, 0), 1'b1);
               else begin
                  for (int i = 0; i < md_count; i++) begin
                     s.cyc = c + 2 + i; s.val = md_buf[i];
                     exp_s.push_back(s);
                  end
                  push_msg(c + 2 + md_count, mk(9, md_count), 1'b1);
                  md_mode = 2; md_rep_end = c + md_count;
               end
            3: begin
                  if (st == 2) begin
                     for (int i = exp_s.size() - 1; i >= 0; i--)
                        if (exp_s[i].cyc > c) exp_s.delete(i);
                     for (int i = exp_m.size() - 1; i >= 0; i--)
                        if (exp_m[i].is_rep && exp_m[i].cyc > c) exp_m.delete(i);
                  end
                  md_mode = 0; md_count = 0; md_err = 1'b0;
               end
            4: begin
                  ns = mode_at(c + 1);
                  if (md_pend == c) md_err = 1'b1;
                  else if (msg_at(c + 1)) begin
                     push_msg(c + 2, mk(10, (ns << 8) | (int'(md_err) << 7) | md_count), 1'b0);
                     md_pend = c + 1;
                  end else push_msg(c + 1, mk(10, (ns << 8) | (int'(md_err) << 7) | md_count), 1'b0);
               end
            default: md_err = 1'b1;
         endcase
      end
   endtask

   task automatic drive(input bit cv, input int op, input int arg, input bit nd,
                        input logic [31:0] d, input bit m);
      logic [20:0] mid;
      mid        = 21'($urandom);
      in_msg_nd  = cv;
      in_msg     = {op[3:0], mid, arg[6:0]};
      in_nd      = nd;
      in_data    = d;
      in_m       = m;
      model_step(cv, op, arg, nd, d, m);
      @(posedge clk);
      #2;
      in_msg_nd  = 1'b0;
      in_nd      = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic cmd(input int op, input int arg);
      drive(1'b1, op, arg, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic samp(input logic [31:0] d, input bit m);
      drive(1'b0, 0, 0, 1'b1, d, m);
   endtask

   // Monitor: match every DUT output against the cycle-stamped expectations.
   int mon_c, mon_i;
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         mon_c = cyc;
         mon_i = -1;
         foreach (exp_s[i]) if (exp_s[i].cyc == mon_c && mon_i < 0) mon_i = i;
         if (out_nd) begin
            if (mon_i < 0) check("unexpected_out_nd", 64'(out_data), 64'hx);
            else begin
               check("replay_sample", 64'({out_m, out_data}), 64'(exp_s[mon_i].val));
               exp_s.delete(mon_i);
            end
         end else if (mon_i >= 0) begin
            check("missing_out_nd", 64'(out_nd), 64'd1);
            exp_s.delete(mon_i);
         end
         mon_i = -1;
         foreach (exp_m[i]) if (exp_m[i].cyc == mon_c && mon_i < 0) mon_i = i;
         if (out_msg_nd) begin
            if (mon_i < 0) check("unexpected_out_msg", 64'(out_msg), 64'hx);
            else begin
               check("response_word", 64'(out_msg), 64'(exp_m[mon_i].word));
               exp_m.delete(mon_i);
            end
         end else if (mon_i >= 0) begin
            check("missing_out_msg", 64'(out_msg_nd), 64'd1);
            exp_m.delete(mon_i);
         end
         check("error_line", 64'(error), 64'(md_err));
      end
   end

   task automatic check_zero_outputs(input string tag);
      check({tag, "_out_data"}, 64'(out_data), 64'd0);
      check({tag, "_out_nd"}, 64'(out_nd), 64'd0);
      check({tag, "_out_m"}, 64'(out_m), 64'd0);
      check({tag, "_out_msg"}, 64'(out_msg), 64'd0);
      check({tag, "_out_msg_nd"}, 64'(out_msg_nd), 64'd0);
      check({tag, "_error"}, 64'(error), 64'd0);
   endtask

   initial begin
      bit cv, nd;
      int op, r, arg;
      rst_n = 1'b0; in_data = '0; in_nd = 1'b0; in_m = '0; in_msg = '0; in_msg_nd = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Capture 8, then replay them.
      cmd(1, 8);
      for (int i = 0; i < 8; i++) samp(32'h100 + 32'(i), i[0]);
      idle(2);
      cmd(2, 0);
      idle(12);

      // Arg 0 means full depth; extra samples are ignored.
      cmd(1, 0);
      for (int i = 0; i < 70; i++) samp($urandom, 1'($urandom));
      idle(2);
      cmd(2, 0);
      idle(70);

      // REPLAY during capture is an error; CLEAR recovers.
      cmd(1, 20);
      for (int i = 0; i < 3; i++) samp($urandom, 1'($urandom));
      drive(1'b1, 2, 0, 1'b1, 32'hCAFE0001, 1'b1);
      for (int i = 0; i < 3; i++) samp($urandom, 1'($urandom));
      cmd(3, 0);
      cmd(4, 0);
      cmd(2, 0);
      idle(4);

      // STATUS colliding with DONE_CAP, then a second STATUS while pending.
      cmd(1, 5);
      for (int i = 0; i < 4; i++) samp($urandom, 1'($urandom));
      drive(1'b1, 4, 0, 1'b1, 32'h5A5A5A5A, 1'b0);
      cmd(4, 0);
      idle(3);
      cmd(3, 0);
      idle(2);

      // Reset in the middle of a 16-sample replay.
      cmd(1, 16);
      for (int i = 0; i < 16; i++) samp($urandom, 1'($urandom));
      idle(2);
      cmd(2, 0);
      idle(6);
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("async_reset");
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_reset();
      chk_en = 1'b1;
      cmd(4, 0);
      idle(3);

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         cv = ($urandom_range(0, 99) < 6);
         r  = $urandom_range(0, 19);
         if (r <= 5) op = 1;
         else if (r <= 10) op = 2;
         else if (r <= 12) op = 3;
         else if (r <= 17) op = 4;
         else op = $urandom_range(0, 15);
         arg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(1, 12);
         nd  = 1'($urandom_range(0, 1));
         drive(cv, op, arg, nd, $urandom, 1'($urandom));
      end
      idle(80);

      check("samples_left_over", 64'(exp_s.size()), 64'd0);
      check("responses_left_over", 64'(exp_m.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
